timer_status_ctrl: RTL and testbench
====================================

Name: timer_status_ctrl

Overview:
Sequences the PPC405 timer facility. Owns the TSR (6 bits: ENW, WIS, WRS[0:1], PIS, FIS), the TCR (10 bits: WP[0:1], WRC[0:1], WIE, PIE, FP[0:1], FIE, ARE) and the PIT decrementer with its auto-reload register. Detects FIT/watchdog tap transitions on the time base, runs the two-stage watchdog state machine, and applies SPR writes. Its TSR/TCR outputs feed the timer SPR-bus select / interrupt-gating logic.

Parameters:
PIT_W, 32, PIT counter and reload register width.

Ports:
CB  input  1  core clock; all state updates on rising edge.
resetL  input  1  asynchronous active-low reset.
tbTick  input  1  time-base increment strobe; one PIT/tap evaluation per strobe.
tbl  input  32  time base lower [0:31], big-endian (bit 31 = 2^0).
sprWrData  input  32  SPR write data [0:31].
tsrClrWe  input  1  TSR write-to-clear strobe.
tcrWe  input  1  TCR write strobe; data in sprWrData[0:9].
pitWe  input  1  PIT write strobe.
timerStatusOutL2  output  6  TSR [0:5].
timerControlL2  output  10  TCR [0:9].
pitCount  output  PIT_W  current PIT value, for mfspr.
wdRstReq  output  2  one-cycle watchdog reset request = WRC; 00 = none.

Behaviour:
- Reset (resetL=0, async): TSR=0, TCR=0, pitCount=0, reload=0, wdRstReq=00, both tap-history flops=0.
- Tap selection. FIT tap from FP: 00->2^9, 01->2^13, 10->2^17, 11->2^21. WDT tap from WP: 00->2^17, 01->2^21, 10->2^25, 11->2^29. tbl index = 31-n.
- Tap history: registered copy of the selected tap bit, updated every cycle.
- Tap event: selected tap bit is 1 and history is 0 (0->1 transition). Events are independent of tbTick.
- After a WP/FP change, the history comparison uses the new tap. A spurious event is permitted in the first cycle after the change.
- FIT: tap event sets FIS.
- Watchdog FSM, advanced by the WDT tap event, states encoded in {ENW, WIS}:
  - 00 -> 10: set ENW.
  - 10 -> 11: set WIS.
  - 11 and WRS=00: WRS<=WRC, and wdRstReq=WRC for exactly one cycle, registered so it appears the cycle after the event. If WRC=00, WRS stays 00 and no request is made.
  - 11 and WRS!=00: no further change.
  - 01: set ENW, giving 11.
- PIT, evaluated on tbTick:
  - pit>1: decrement.
  - pit==1: pit<=0 and set PIS. If ARE=1, load reload instead of 0; PIS is still set.
  - pit==0: hold, no event.
- pitWe: pit<=sprWrData and reload<=sprWrData. This overrides a same-cycle decrement, and no PIS is set that cycle.
- tcrWe: TCR<=sprWrData[0:9], except that WRC is sticky. Once WRC!=00 it ignores writes until reset.
- tsrClrWe: each TSR bit whose sprWrData[i]=1 is cleared.
  - A same-cycle hardware set of that bit wins (bit ends 1).
  - WRS is cleared as a field if either bit is 1.
- Outputs are registered state; no combinational path from inputs to outputs.
- Multiple strobes in one cycle are legal and apply independently.

Decomposition:
- Shared package:
  - TSR bit-index constants: TSR_ENW=0, TSR_WIS=1, TSR_WRS=2:3, TSR_PIS=4, TSR_FIS=5.
  - TCR field-index constants.
  - Tap-select encodings.
- One sub-module is natural: timer_tap_detect. It performs 4:1 tap mux, history flop and rising-edge pulse, and is instantiated twice (FIT, WDT).

Test Plan:
1. Reset mid-count: pit=5, assert resetL=0 -> TSR=0, TCR=0, pitCount=0, wdRstReq=00 immediately, without a CB edge.
2. PIT auto-reload: ARE=1, write PIT=3, 3 tbTicks -> pitCount 2,1,3. PIS=1 after the third tick. With ARE=0, pit ends at 0, PIS=1, and further ticks hold 0.
3. Write vs. decrement collision: pit=1, pitWe with data 0x10 in the same cycle as tbTick -> pitCount=0x10, PIS=0.
4. Watchdog sequence: WP=00, WRC=10, three 0->1 transitions of tbl[14].
   - TSR[0:3] goes 1000, 1100, 1110.
   - wdRstReq=10 for one cycle only.
   - A fourth event causes no change.
5. WRC sticky: write TCR WRC=01, then write WRC=00 -> WRC stays 01. After reset, WRC=00.
6. Clear vs. set: FP=00, tsrClrWe with data bit5=1 in the same cycle as a tbl[22] rising edge -> FIS=1. The next clear with no event gives FIS=0.

Source files
------------

// File: rtl/timer_status_ctrl_pkg.sv
// Shared constants for the PPC405 timer facility: TSR/TCR field positions and tap selection.
package timer_status_ctrl_pkg;

  localparam int unsigned TSR_W = 6;
  localparam int unsigned TCR_W = 10;

  // TSR bit indices, big-endian [0:5]
  localparam int unsigned TSR_ENW  = 0;
  localparam int unsigned TSR_WIS  = 1;
  localparam int unsigned TSR_WRS0 = 2;
  localparam int unsigned TSR_WRS1 = 3;
  localparam int unsigned TSR_PIS  = 4;
  localparam int unsigned TSR_FIS  = 5;

  // TCR field indices, big-endian [0:9]
  localparam int unsigned TCR_WP0  = 0;
  localparam int unsigned TCR_WP1  = 1;
  localparam int unsigned TCR_WRC0 = 2;
  localparam int unsigned TCR_WRC1 = 3;
  localparam int unsigned TCR_WIE  = 4;
  localparam int unsigned TCR_PIE  = 5;
  localparam int unsigned TCR_FP0  = 6;
  localparam int unsigned TCR_FP1  = 7;
  localparam int unsigned TCR_FIE  = 8;
  localparam int unsigned TCR_ARE  = 9;

  typedef enum logic [1:0] {
    TapSel0 = 2'b00,
    TapSel1 = 2'b01,
    TapSel2 = 2'b10,
    TapSel3 = 2'b11
  } tap_sel_e;

  // Watchdog state as held in {ENW, WIS}
  typedef enum logic [1:0] {
    WdIdle    = 2'b00,
    WdIntOnly = 2'b01,
    WdEnabled = 2'b10,
    WdTimeout = 2'b11
  } wd_state_e;

  // Tap n selects time-base weight 2^(base + step*sel)
  localparam int unsigned FIT_TAP_BASE = 9;
  localparam int unsigned WDT_TAP_BASE = 17;
  localparam int unsigned TAP_STEP     = 4;

  function automatic logic [3:0] tap_vec(input logic [0:31] tbl, input int unsigned base);
    logic [3:0] v;
    v = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      v[i] = tbl[31 - (base + TAP_STEP * i)];
    end
    return v;
  endfunction

endpackage

// File: rtl/timer_status_ctrl_tap_detect.sv
// Selects one of four time-base taps and pulses on its 0->1 transition.
module timer_tap_detect
  import timer_status_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] taps_i,
  input  tap_sel_e   sel_i,
  output logic       event_o
);

  logic tap;
  logic hist_q;

  always_comb begin
    tap = 1'b0;
    unique case (sel_i)
      TapSel0: tap = taps_i[0];
      TapSel1: tap = taps_i[1];
      TapSel2: tap = taps_i[2];
      TapSel3: tap = taps_i[3];
      default: tap = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= tap;
    end
  end

  assign event_o = tap & ~hist_q;

endmodule

// File: rtl/timer_status_ctrl.sv
// PPC405 timer status/control: TSR, TCR, PIT decrementer and two-stage watchdog.
module timer_status_ctrl
  import timer_status_ctrl_pkg::*;
#(
  parameter int unsigned PIT_W = 32
) (
  input  logic             CB,
  input  logic             resetL,
  input  logic             tbTick,
  input  logic [0:31]      tbl,
  input  logic [0:31]      sprWrData,
  input  logic             tsrClrWe,
  input  logic             tcrWe,
  input  logic             pitWe,
  output logic [0:5]       timerStatusOutL2,
  output logic [0:9]       timerControlL2,
  output logic [PIT_W-1:0] pitCount,
  output logic [0:1]       wdRstReq
);

  localparam int unsigned PitLsbOff = 32 - PIT_W;

  logic [0:5]       tsr_q, tsr_d;
  logic [0:9]       tcr_q, tcr_d;
  logic [PIT_W-1:0] pit_q, pit_d;
  logic [PIT_W-1:0] reload_q, reload_d;
  logic [0:1]       wd_req_q, wd_req_d;

  logic             fit_event, wdt_event;
  logic [0:5]       wd_set, hw_set, clr_mask;
  logic             pis_set;
  logic [0:1]       wrc, wrs;
  logic [PIT_W-1:0] pit_ld;
  wd_state_e        wd_state;

  assign wrc      = tcr_q[TCR_WRC0:TCR_WRC1];
  assign wrs      = tsr_q[TSR_WRS0:TSR_WRS1];
  assign wd_state = wd_state_e'({tsr_q[TSR_ENW], tsr_q[TSR_WIS]});
  assign pit_ld   = sprWrData[PitLsbOff +: PIT_W];

  timer_tap_detect u_fit_tap (
    .clk_i   (CB),
    .rst_ni  (resetL),
    .taps_i  (tap_vec(tbl, FIT_TAP_BASE)),
    .sel_i   (tap_sel_e'(tcr_q[TCR_FP0:TCR_FP1])),
    .event_o (fit_event)
  );

  timer_tap_detect u_wdt_tap (
    .clk_i   (CB),
    .rst_ni  (resetL),
    .taps_i  (tap_vec(tbl, WDT_TAP_BASE)),
    .sel_i   (tap_sel_e'(tcr_q[TCR_WP0:TCR_WP1])),
    .event_o (wdt_event)
  );

  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      tsr_q    <= '0;
      tcr_q    <= '0;
      pit_q    <= '0;
      reload_q <= '0;
      wd_req_q <= '0;
    end else begin
      tsr_q    <= tsr_d;
      tcr_q    <= tcr_d;
      pit_q    <= pit_d;
      reload_q <= reload_d;
      wd_req_q <= wd_req_d;
    end
  end

  // Watchdog next-state: advances only on a WDT tap event
  always_comb begin
    wd_set = '0;
    if (wdt_event) begin
      unique case (wd_state)
        WdIdle, WdIntOnly: wd_set[TSR_ENW] = 1'b1;
        WdEnabled:         wd_set[TSR_WIS] = 1'b1;
        WdTimeout: begin
          if (wrs == 2'b00) wd_set[TSR_WRS0:TSR_WRS1] = wrc;
        end
        default: wd_set = '0;
      endcase
    end
  end

  // Reset request fires once, on the event that first latches WRS
  always_comb begin
    wd_req_d = 2'b00;
    if (wdt_event && wd_state == WdTimeout && wrs == 2'b00) wd_req_d = wrc;
  end

  always_comb begin
    pit_d    = pit_q;
    reload_d = reload_q;
    pis_set  = 1'b0;
    if (pitWe) begin
      pit_d    = pit_ld;
      reload_d = pit_ld;
    end else if (tbTick) begin
      if (pit_q > PIT_W'(1)) begin
        pit_d = pit_q - PIT_W'(1);
      end else if (pit_q == PIT_W'(1)) begin
        pit_d   = tcr_q[TCR_ARE] ? reload_q : '0;
        pis_set = 1'b1;
      end
    end
  end

  // Hardware sets win over a same-cycle write-to-clear
  always_comb begin
    hw_set          = wd_set;
    hw_set[TSR_PIS] = pis_set;
    hw_set[TSR_FIS] = fit_event;
    clr_mask        = tsrClrWe ? sprWrData[0:5] : '0;
    if (clr_mask[TSR_WRS0] || clr_mask[TSR_WRS1]) clr_mask[TSR_WRS0:TSR_WRS1] = 2'b11;
    tsr_d = (tsr_q & ~clr_mask) | hw_set;
  end

  always_comb begin
    tcr_d = tcr_q;
    if (tcrWe) begin
      tcr_d = sprWrData[0:9];
      if (wrc != 2'b00) tcr_d[TCR_WRC0:TCR_WRC1] = wrc;
    end
  end

  assign timerStatusOutL2 = tsr_q;
  assign timerControlL2   = tcr_q;
  assign pitCount         = pit_q;
  assign wdRstReq         = wd_req_q;

endmodule

// File: tb/tb_timer_status_ctrl.sv
// Directed and randomized checks of timer_status_ctrl against a rule-level reference model.
module tb_timer_status_ctrl;

  logic        CB;
  logic        resetL;
  logic        tbTick;
  logic [0:31] tbl;
  logic [0:31] sprWrData;
  logic        tsrClrWe, tcrWe, pitWe;
  logic [0:5]  timerStatusOutL2;
  logic [0:9]  timerControlL2;
  logic [31:0] pitCount;
  logic [0:1]  wdRstReq;

  int errors;
  int checks;

  // Reference model state
  logic [0:5]  m_tsr;
  logic [0:9]  m_tcr;
  logic [31:0] m_pit, m_reload;
  logic [0:1]  m_req;
  logic        m_fit_hist, m_wdt_hist;

  localparam logic [31:0] TB14 = 32'h0002_0000;  // weight 2^17
  localparam logic [31:0] TB22 = 32'h0000_0200;  // weight 2^9
  localparam logic [31:0] ALL6 = 32'hFC00_0000;
  localparam logic [31:0] BIT5 = 32'h0400_0000;

  timer_status_ctrl #(.PIT_W(32)) dut (
    .CB               (CB),
    .resetL           (resetL),
    .tbTick           (tbTick),
    .tbl              (tbl),
    .sprWrData        (sprWrData),
    .tsrClrWe         (tsrClrWe),
    .tcrWe            (tcrWe),
    .pitWe            (pitWe),
    .timerStatusOutL2 (timerStatusOutL2),
    .timerControlL2   (timerControlL2),
    .pitCount         (pitCount),
    .wdRstReq         (wdRstReq)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tsr"}, 32'(timerStatusOutL2), 32'(m_tsr));
    chk({tag, ".tcr"}, 32'(timerControlL2), 32'(m_tcr));
    chk({tag, ".pit"}, pitCount, m_pit);
    chk({tag, ".req"}, 32'(wdRstReq), 32'(m_req));
  endtask

  task automatic model_reset;
    m_tsr      = '0;
    m_tcr      = '0;
    m_pit      = '0;
    m_reload   = '0;
    m_req      = '0;
    m_fit_hist = 1'b0;
    m_wdt_hist = 1'b0;
  endtask

  function automatic logic [31:0] tcr_word(input logic [1:0] wp, input logic [1:0] wrc,
                                           input logic [1:0] fp, input logic are);
    logic [0:31] d;
    d      = '0;
    d[0:1] = wp;
    d[2:3] = wrc;
    d[6:7] = fp;
    d[9]   = are;
    return d;
  endfunction

  // Drive one cycle of inputs, predict from the rules, then compare after the edge
  task automatic step(input string tag, input logic tick, input logic [31:0] tb,
                      input logic [31:0] dw, input logic clr, input logic tw, input logic pw);
    logic [0:31] t, d;
    int          fn, wn;
    logic        fbit, wbit, fev, wev;
    logic [0:5]  set, cmask, ntsr;
    logic [0:9]  ntcr;
    logic [31:0] npit, nrel;
    logic [0:1]  nreq;
    t = tb;
    d = dw;
    tbTick = tick; tbl = t; sprWrData = d; tsrClrWe = clr; tcrWe = tw; pitWe = pw;
    fn   = 9 + 4 * int'(m_tcr[6:7]);
    wn   = 17 + 4 * int'(m_tcr[0:1]);
    fbit = t[31 - fn];
    wbit = t[31 - wn];
    fev  = fbit & ~m_fit_hist;
    wev  = wbit & ~m_wdt_hist;
    set  = '0;
    nreq = 2'b00;
    if (fev) set[5] = 1'b1;
    if (wev) begin
      if (!m_tsr[0]) set[0] = 1'b1;
      else if (!m_tsr[1]) set[1] = 1'b1;
      else if (m_tsr[2:3] == 2'b00) begin
        set[2:3] = m_tcr[2:3];
        nreq     = m_tcr[2:3];
      end
    end
    npit = m_pit;
    nrel = m_reload;
    if (pw) begin
      npit = dw;
      nrel = dw;
    end else if (tick) begin
      if (m_pit > 1) npit = m_pit - 1;
      else if (m_pit == 1) begin
        npit   = m_tcr[9] ? m_reload : 32'd0;
        set[4] = 1'b1;
      end
    end
    cmask = clr ? d[0:5] : 6'b0;
    if (cmask[2] || cmask[3]) cmask[2:3] = 2'b11;
    ntsr = (m_tsr & ~cmask) | set;
    ntcr = m_tcr;
    if (tw) begin
      ntcr = d[0:9];
      if (m_tcr[2:3] != 2'b00) ntcr[2:3] = m_tcr[2:3];
    end
    @(posedge CB);
    #1;
    m_tsr = ntsr; m_tcr = ntcr; m_pit = npit; m_reload = nrel; m_req = nreq;
    m_fit_hist = fbit;
    m_wdt_hist = wbit;
    check_all(tag);
  endtask

  // Assert reset between edges and check outputs before any clock edge
  task automatic apply_reset(input string tag);
    tbTick = 0; tbl = '0; sprWrData = '0; tsrClrWe = 0; tcrWe = 0; pitWe = 0;
    #2;
    resetL = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CB);
    resetL = 1'b1;
    @(posedge CB);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetL = 1'b0;
    model_reset();
    apply_reset("por");

    // Reset mid-count
    step("ld5", 0, 0, 32'd5, 0, 0, 1);
    step("dec", 1, 0, 0, 0, 0, 0);
    chk("pit_mid", pitCount, 32'd4);
    apply_reset("rst_mid");
    chk("pit_after_rst", pitCount, 32'd0);

    // Auto-reload
    step("are1", 0, 0, tcr_word(2'b00, 2'b00, 2'b00, 1'b1), 0, 1, 0);
    step("ld3", 0, 0, 32'd3, 0, 0, 1);
    step("t1", 1, 0, 0, 0, 0, 0);
    chk("are_p2", pitCount, 32'd2);
    step("t2", 1, 0, 0, 0, 0, 0);
    chk("are_p1", pitCount, 32'd1);
    step("t3", 1, 0, 0, 0, 0, 0);
    chk("are_p3", pitCount, 32'd3);
    chk("are_pis", 32'(timerStatusOutL2[4]), 32'd1);

    // No reload: pit sticks at zero
    step("are0", 0, 0, tcr_word(2'b00, 2'b00, 2'b00, 1'b0), 0, 1, 0);
    step("clr", 0, 0, ALL6, 1, 0, 0);
    step("ld2", 0, 0, 32'd2, 0, 0, 1);
    step("n1", 1, 0, 0, 0, 0, 0);
    step("n2", 1, 0, 0, 0, 0, 0);
    chk("noare_pis", 32'(timerStatusOutL2[4]), 32'd1);
    step("n3", 1, 0, 0, 0, 0, 0);
    step("n4", 1, 0, 0, 0, 0, 0);
    chk("noare_hold", pitCount, 32'd0);

    // Write beats decrement
    step("clr2", 0, 0, ALL6, 1, 0, 0);
    step("ld1", 0, 0, 32'd1, 0, 0, 1);
    step("coll", 1, 0, 32'h10, 0, 0, 1);
    chk("coll_pit", pitCount, 32'h10);
    chk("coll_pis", 32'(timerStatusOutL2[4]), 32'd0);

    // WRC sticky
    step("wrc01", 0, 0, tcr_word(2'b00, 2'b01, 2'b00, 1'b0), 0, 1, 0);
    step("wrc00", 0, 0, tcr_word(2'b00, 2'b00, 2'b00, 1'b0), 0, 1, 0);
    chk("wrc_sticky", 32'(timerControlL2[2:3]), 32'd1);
    apply_reset("rst_wrc");
    chk("wrc_reset", 32'(timerControlL2[2:3]), 32'd0);

    // Watchdog sequence, WP=00 -> tbl[14]
    step("wrc10", 0, 0, tcr_word(2'b00, 2'b10, 2'b00, 1'b0), 0, 1, 0);
    step("wd_e1", 0, TB14, 0, 0, 0, 0);
    chk("wd_1000", 32'(timerStatusOutL2[0:3]), 32'b1000);
    step("wd_l1", 0, 0, 0, 0, 0, 0);
    step("wd_e2", 0, TB14, 0, 0, 0, 0);
    chk("wd_1100", 32'(timerStatusOutL2[0:3]), 32'b1100);
    step("wd_l2", 0, 0, 0, 0, 0, 0);
    step("wd_e3", 0, TB14, 0, 0, 0, 0);
    chk("wd_1110", 32'(timerStatusOutL2[0:3]), 32'b1110);
    chk("wd_req", 32'(wdRstReq), 32'b10);
    step("wd_l3", 0, 0, 0, 0, 0, 0);
    chk("wd_req_drop", 32'(wdRstReq), 32'b00);
    step("wd_e4", 0, TB14, 0, 0, 0, 0);
    chk("wd_e4_tsr", 32'(timerStatusOutL2[0:3]), 32'b1110);
    chk("wd_e4_req", 32'(wdRstReq), 32'b00);

    // Clear vs. same-cycle FIT set, FP=00 -> tbl[22]
    step("fp00", 0, 0, tcr_word(2'b00, 2'b00, 2'b00, 1'b0), 0, 1, 0);
    step("fis_race", 0, TB22, BIT5, 1, 0, 0);
    chk("fis_set_wins", 32'(timerStatusOutL2[5]), 32'd1);
    step("fis_clr", 0, TB22, BIT5, 1, 0, 0);
    chk("fis_cleared", 32'(timerStatusOutL2[5]), 32'd0);

    // Randomized traffic
    apply_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      logic        rt, rc, rw, rp;
      logic [31:0] rtb, rd;
      rt  = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 5) == 0);
      rw  = ($urandom_range(0, 7) == 0);
      rp  = ($urandom_range(0, 5) == 0);
      rtb = $urandom;
      rd  = rp ? 32'($urandom_range(0, 5)) : $urandom;
      step("rand", rt, rtb, rd, rc, rw, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
